// File: rtl/generic_bus_ram_responder.sv
// generic_bus_ram_responder: word-addressed RAM responder with programmable wait states,
// byte-enable writes, out-of-range flagging, request-withdrawal abort and stall injection.
module generic_bus_ram_responder #(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] OOR_DATA  = 32'hBAD1_BAD1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [3:0]  i_byte_en,
    input  logic        i_stall_inject,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_oor
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_wr;
    logic          r_in_range;
    logic [3:0]    r_cnt;
    logic [31:0]   r_rdata;

    logic [29:0]   w_word;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_req;
    logic          w_from_idle;
    logic [AW-1:0] w_rd_idx;
    logic          w_rd_in_range;
    logic          w_rd_kind;
    logic          w_enter_resp;
    logic          w_commit;
    logic [31:0]   w_mask;

    // Offset wraps modulo 2^32; the two byte-select bits are dropped by the shift.
    assign w_word     = 30'((i_addr - BASE_ADDR) >> 2);
    assign w_idx      = w_word[AW-1:0];
    assign w_in_range = w_word < 30'(DEPTH);
    assign w_req      = i_ren | i_wen;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_req ? ((LATENCY == 0) ? S_RESP : S_WAIT) : S_IDLE;
            S_WAIT:  w_next = !w_req ? S_IDLE : (!i_stall_inject && r_cnt == 4'd1) ? S_RESP : S_WAIT;
            S_RESP:  w_next = i_stall_inject ? S_RESP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = !(r_state == S_RESP && !i_stall_inject);
        o_oor   = r_state == S_RESP && !i_stall_inject && !r_in_range;
        o_rdata = r_rdata;
    end

    // With zero latency RESP is entered straight from IDLE, so the read uses the live request.
    assign w_from_idle   = r_state == S_IDLE;
    assign w_rd_idx      = w_from_idle ? w_idx : r_idx;
    assign w_rd_in_range = w_from_idle ? w_in_range : r_in_range;
    assign w_rd_kind     = w_from_idle ? !i_wen : !r_wr;
    assign w_enter_resp  = r_state != S_RESP && w_next == S_RESP;
    assign w_commit      = r_state == S_RESP && !i_stall_inject && r_wr && r_in_range;
    assign w_mask        = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_wr       <= 1'b0;
            r_in_range <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_idx      <= w_idx;
                r_wdata    <= i_wdata;
                r_be       <= i_byte_en;
                r_wr       <= i_wen;
                r_in_range <= w_in_range;
                r_cnt      <= 4'(LATENCY);
            end else if (r_state == S_WAIT && !i_stall_inject && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp && w_rd_kind)
                r_rdata <= w_rd_in_range ? r_mem[w_rd_idx] : OOR_DATA;
        end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge i_clk or negedge i_rst_n)
            if (!i_rst_n)                            r_mem[g] <= '0;
            else if (w_commit && r_idx == AW'(g))    r_mem[g] <= (r_mem[g] & ~w_mask) | (r_wdata & w_mask);
    end
endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// tb_generic_bus_ram_responder: four responders (LATENCY 2,3,1,0) driven by directed and
// random transactions, checked against an array model of the RAM and the latency rule.
module tb_generic_bus_ram_responder;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] OOR   = 32'hBAD1_BAD1;

    logic        clk = 1'b0;
    logic        rst_n [4];
    logic [31:0] addr [4];
    logic [31:0] wdata [4];
    logic        ren [4];
    logic        wen [4];
    logic [3:0]  be [4];
    logic        stall [4];
    logic [31:0] rdata [4];
    logic        busy [4];
    logic        oor [4];

    logic [31:0] model [4][DEPTH];
    logic [31:0] exp_rd [4];
    int          n_chk = 0;
    int          n_fail = 0;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        generic_bus_ram_responder #(
            .DEPTH(DEPTH),
            .LATENCY(k == 0 ? 2 : k == 1 ? 3 : k == 2 ? 1 : 0),
            .BASE_ADDR(BASE),
            .OOR_DATA(OOR)
        ) u_dut (
            .i_clk(clk),
            .i_rst_n(rst_n[k]),
            .i_addr(addr[k]),
            .i_wdata(wdata[k]),
            .i_ren(ren[k]),
            .i_wen(wen[k]),
            .i_byte_en(be[k]),
            .i_stall_inject(stall[k]),
            .o_rdata(rdata[k]),
            .o_busy(busy[k]),
            .o_oor(oor[k])
        );
    end

    initial forever #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return d == 0 ? 2 : d == 1 ? 3 : d == 2 ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
        exp_rd[d] = '0;
    endtask

    // One complete transaction; stall is high for ns cycles starting st cycles after issue.
    task automatic txn(input int d, input bit is_wr, input bit both, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] bm, input int st, input int ns,
                       input string tag);
        int          done_exp;
        int          seen;
        int          idx;
        bit          inr;
        logic [31:0] off;
        logic [31:0] got_rd;
        logic        got_oor;
        logic [31:0] w;
        done_exp = lat_of(d) + 1 + ns;
        off = a - BASE;
        inr = (off >> 2) < DEPTH;
        idx = int'((off >> 2) % DEPTH);
        addr[d] = a; wdata[d] = wd; be[d] = bm;
        wen[d] = is_wr; ren[d] = !is_wr || both; stall[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("%s issue_busy d%0d", tag, d), 32'(busy[d]), 32'd1);
        seen = -1; got_rd = '0; got_oor = 1'b0;
        for (int k = 1; seen < 0 && k <= done_exp + 4; k++) begin
            tick();
            stall[d] = (k >= st && k < st + ns);
            addr[d] = $urandom; wdata[d] = $urandom;
            @(negedge clk);
            if (busy[d] === 1'b0) begin
                seen = k; got_rd = rdata[d]; got_oor = oor[d];
            end
        end
        tick();
        ren[d] = 1'b0; wen[d] = 1'b0; stall[d] = 1'b0;
        if (!is_wr) exp_rd[d] = inr ? model[d][idx] : OOR;
        chk($sformatf("%s done_cycle d%0d", tag, d), 32'(seen), 32'(done_exp));
        chk($sformatf("%s rdata d%0d", tag, d), got_rd, exp_rd[d]);
        chk($sformatf("%s oor d%0d", tag, d), 32'(got_oor), 32'(!inr));
        if (is_wr && inr) begin
            w = model[d][idx];
            for (int b = 0; b < 4; b++) if (bm[b]) w[8*b +: 8] = wd[8*b +: 8];
            model[d][idx] = w;
        end
    endtask

    task automatic rd(input int d, input logic [31:0] a, input string tag);
        txn(d, 1'b0, 1'b0, a, 32'h0, 4'h0, 1, 0, tag);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bm, input string tag);
        txn(d, 1'b1, 1'b0, a, wd, bm, 1, 0, tag);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b2b_a [4];
        int          zeros;
        int          d;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            rst_n[i] = 1'b0; addr[i] = '0; wdata[i] = '0; ren[i] = 1'b0;
            wen[i] = 1'b0; be[i] = '0; stall[i] = 1'b0;
            model_reset(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset busy d%0d", i), 32'(busy[i]), 32'd1);
            chk($sformatf("reset rdata d%0d", i), rdata[i], 32'h0);
            chk($sformatf("reset oor d%0d", i), 32'(oor[i]), 32'd0);
        end
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
        tick();

        wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, "wr_basic");
        rd(0, 32'h8000_0010, "rd_basic");
        wr(0, 32'h8000_0020, 32'h1122_3344, 4'hF, "lane_init");
        wr(0, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, "lane_wr");
        rd(0, 32'h8000_0022, "lane_rd");
        wr(0, 32'h8000_0024, 32'h5555_AAAA, 4'h0, "be_zero");
        rd(0, 32'h8000_0024, "be_zero_rd");

        wr(0, 32'h8000_03FC, 32'h0BAD_F00D, 4'hF, "last_word");
        rd(0, 32'h8000_0400, "oor_rd");
        wr(0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, "oor_wr");
        rd(0, 32'h8000_03FC, "oor_wr_last");
        rd(0, 32'h8000_0000, "oor_wr_first");
        txn(0, 1'b1, 1'b1, 32'h8000_0030, 32'h7777_8888, 4'hF, 1, 0, "both_req");
        rd(0, 32'h8000_0030, "both_rd");

        wr(1, 32'h8000_0040, 32'hCAFE_0001, 4'hF, "abort_init");
        addr[1] = 32'h8000_0040; wdata[1] = 32'h1234_5678; be[1] = 4'hF; wen[1] = 1'b1;
        tick();
        wen[1] = 1'b0;
        zeros = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy[1] !== 1'b1) zeros++;
            tick();
        end
        chk("abort busy_zero_cycles d1", 32'(zeros), 32'd0);
        rd(1, 32'h8000_0040, "abort_rd");

        wr(2, 32'h8000_0050, 32'h0F0F_1234, 4'hF, "stall_init");
        txn(2, 1'b0, 1'b0, 32'h8000_0050, 32'h0, 4'h0, 1, 3, "stall_wait");
        txn(0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 3, 2, "stall_resp");
        txn(3, 1'b1, 1'b0, 32'h8000_0060, 32'h4242_4242, 4'hF, 1, 2, "stall_l0");

        for (int i = 0; i < 4; i++) begin
            b2b_a[i] = BASE + 32'(i * 4 + 96);
            wr(3, b2b_a[i], $urandom | 32'h1, 4'hF, "b2b_init");
        end
        addr[3] = b2b_a[0]; ren[3] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k % 2 == 0) addr[3] = b2b_a[k / 2];
            @(negedge clk);
            chk($sformatf("b2b busy k%0d", k), 32'(busy[3]), 32'(k % 2 == 0));
            if (k % 2 == 1) begin
                exp_rd[3] = model[3][24 + (k - 1) / 2];
                chk($sformatf("b2b rdata k%0d", k), rdata[3], exp_rd[3]);
            end
        end
        tick();
        ren[3] = 1'b0;

        for (int i = 0; i < 48; i++) begin
            d = int'($urandom_range(0, 3));
            lat = lat_of(d);
            case ($urandom_range(0, 7))
                0:       a = BASE + 32'(DEPTH * 4) + $urandom_range(0, 4095);
                1:       a = BASE - 32'd4 - $urandom_range(0, 4095);
                default: a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            endcase
            txn(d, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, a, $urandom,
                4'($urandom), int'($urandom_range(1, lat + 1)), int'($urandom_range(0, 2)), "rand");
        end

        wr(1, 32'h8000_0070, 32'h600D_600D, 4'hF, "rst_init");
        rd(1, 32'h8000_0070, "rst_pre_rd");
        addr[1] = 32'h8000_0070; wdata[1] = 32'hDEAD_0000; be[1] = 4'hF; wen[1] = 1'b1;
        tick();
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk("midwait_rst busy d1", 32'(busy[1]), 32'd1);
        chk("midwait_rst rdata d1", rdata[1], 32'h0);
        chk("midwait_rst oor d1", 32'(oor[1]), 32'd0);
        wen[1] = 1'b0;
        model_reset(1);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        tick();
        rd(1, 32'h8000_0070, "rst_post_rd");
        rd(1, 32'h8000_0040, "rst_post_rd2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
